// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the uart_core frame decoder slice.
package uart_frame_pkg;

    // Frame parser states
    typedef enum logic [1:0] {
        HUNT,
        LEN,
        PAY,
        CHK
    } parser_state_t;

    // Rx FIFO fetch engine states
    typedef enum logic [1:0] {
        F_IDLE,
        F_PULSE,
        F_WAIT
    } fetch_state_t;

    // Default start-of-frame marker
    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_rx_fetch.sv
// Drains uart_core's Rx FIFO one byte at a time. Each byte costs one
// rx_pulse cycle plus RD_WAIT quiet cycles, so uart_core's edge detector
// always sees a clean low-then-high per pop. rx_data is taken on the last
// quiet cycle, when byte_strobe is high for exactly that cycle.
// Handshake: rx_empty is only looked at in F_IDLE; a byte is consumed by
// the caller in the single cycle byte_strobe=1, with rx_byte valid then.
module uart_rx_fetch
    import uart_frame_pkg::*;
#(
    parameter int RD_WAIT = 3
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rx_empty,
    input  logic [7:0] rx_data,
    output logic       rx_pulse,
    output logic [7:0] rx_byte,
    output logic       byte_strobe
);

    localparam int WW = (RD_WAIT < 2) ? 1 : $clog2(RD_WAIT + 1);

    fetch_state_t   state;
    fetch_state_t   state_next;
    logic [WW-1:0]  wait_cnt;

    assign rx_byte = rx_data;

    // Fetch state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= F_IDLE;
        else       state <= state_next;
    end

    // Quiet-cycle counter, restarted by every pulse
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)                  wait_cnt <= '0;
        else if (state == F_PULSE)  wait_cnt <= '0;
        else if (state == F_WAIT)   wait_cnt <= wait_cnt + WW'(1);
    end

    // Next-state and pulse/strobe decode
    always_comb begin
        state_next  = state;
        rx_pulse    = 1'b0;
        byte_strobe = 1'b0;
        case (state)
            F_IDLE: begin
                if (!rx_empty) state_next = F_PULSE;
            end
            F_PULSE: begin
                rx_pulse   = 1'b1;
                state_next = F_WAIT;
            end
            F_WAIT: begin
                if (wait_cnt == WW'(RD_WAIT - 1)) begin
                    byte_strobe = 1'b1;
                    state_next  = F_IDLE;
                end
            end
            default: state_next = F_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_frame_decoder.sv
// Parses SOF / LEN / payload / checksum frames from uart_core's Rx FIFO.
// Payload bytes are streamed as they arrive; frame_ok or frame_err follows
// once the checksum (sum of LEN and payload, mod 256) is seen, or a frame
// is abandoned on a bad LEN or an inter-byte gap timeout.
// m_valid/m_last/frame_ok/frame_err are single-cycle strobes with no
// backpressure: the consumer must take them in the cycle they appear.
module uart_frame_decoder
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE       = SOF_DEFAULT,
    parameter int         MAX_LEN        = 64,
    parameter int         RD_WAIT        = 3,
    parameter int         TIMEOUT_CYCLES = 416_667
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] rx_data,
    input  logic       rx_empty,
    output logic       rx_pulse,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [7:0] err_count,
    output logic       busy
);

    localparam int         TW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [7:0] MAX_B = 8'(MAX_LEN);

    logic [7:0]    rx_byte;
    logic          byte_strobe;
    parser_state_t state;
    parser_state_t state_next;
    logic [7:0]    len_r;
    logic [7:0]    cnt;
    logic [7:0]    sum;
    logic [TW-1:0] tmo;
    logic [7:0]    cnt_inc;
    logic          timeout_hit;
    logic          pay_fire;
    logic          last_fire;
    logic          ok_fire;
    logic          err_fire;

    uart_rx_fetch #(.RD_WAIT(RD_WAIT)) u_fetch (
        .clk         (clk),
        .nrst        (nrst),
        .rx_empty    (rx_empty),
        .rx_data     (rx_data),
        .rx_pulse    (rx_pulse),
        .rx_byte     (rx_byte),
        .byte_strobe (byte_strobe)
    );

    assign busy    = (state != HUNT);
    assign cnt_inc = cnt + 8'd1;
    // The gap counter is about to reach TIMEOUT_CYCLES-1; a byte arriving
    // in the same cycle takes priority and restarts the count instead.
    assign timeout_hit = busy && !byte_strobe && (tmo == TW'(TIMEOUT_CYCLES - 2));

    // Parser state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= HUNT;
        else       state <= state_next;
    end

    // Parser next-state and per-byte event decode
    always_comb begin
        state_next = state;
        pay_fire   = 1'b0;
        last_fire  = 1'b0;
        ok_fire    = 1'b0;
        err_fire   = 1'b0;
        if (byte_strobe) begin
            case (state)
                HUNT: begin
                    if (rx_byte == SOF_BYTE) state_next = LEN;
                end
                LEN: begin
                    if (rx_byte == 8'd0 || rx_byte > MAX_B) begin
                        err_fire   = 1'b1;
                        state_next = HUNT;
                    end else begin
                        state_next = PAY;
                    end
                end
                PAY: begin
                    pay_fire = 1'b1;
                    if (cnt_inc == len_r) begin
                        last_fire  = 1'b1;
                        state_next = CHK;
                    end
                end
                CHK: begin
                    if (rx_byte == sum) ok_fire  = 1'b1;
                    else                err_fire = 1'b1;
                    state_next = HUNT;
                end
                default: state_next = HUNT;
            endcase
        end else if (timeout_hit) begin
            err_fire   = 1'b1;
            state_next = HUNT;
        end
    end

    // Output strobes, payload byte and saturating error counter
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_data    <= 8'd0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_count <= 8'd0;
        end else begin
            m_valid   <= pay_fire;
            m_last    <= last_fire;
            frame_ok  <= ok_fire;
            frame_err <= err_fire;
            if (pay_fire)                       m_data    <= rx_byte;
            if (err_fire && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

    // Frame length, payload count and running checksum
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            len_r <= 8'd0;
            cnt   <= 8'd0;
            sum   <= 8'd0;
        end else if (byte_strobe && state == LEN) begin
            len_r <= rx_byte;
            cnt   <= 8'd0;
            sum   <= rx_byte;
        end else if (pay_fire) begin
            cnt   <= cnt_inc;
            sum   <= sum + rx_byte;
        end
    end

    // Inter-byte gap counter, only running while inside a frame
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)                        tmo <= '0;
        else if (byte_strobe || !busy)    tmo <= '0;
        else                              tmo <= tmo + TW'(1);
    end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Bench for uart_frame_decoder: a uart_core Rx FIFO model feeds byte
// sequences, a frame-level model predicts the output event stream, and a
// compare process checks every output strobe against it.
module tb_uart_frame_decoder;

    localparam int         RD_WAIT = 3;
    localparam int         TIMEOUT = 1000;
    localparam int         MAX_LEN = 64;
    localparam logic [7:0] SOF     = 8'hA5;

    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic [7:0] rx_data = 8'd0;
    logic       rx_empty = 1'b1;
    logic       rx_pulse;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       frame_ok;
    logic       frame_err;
    logic [7:0] err_count;
    logic       busy;

    // Event encoding: [9:8] = 0 payload, 1 payload+last, 2 ok, 3 err
    logic [9:0] exp_q[$];
    logic [7:0] fifo_q[$];
    logic [7:0] seq[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int model_err = 0;
    int pushed = 0;
    int pops = 0;
    int last_pulse_cyc = 0;
    int high_run = 0;
    int low_run = 0;
    bit seen_pulse = 1'b0;

    uart_frame_decoder #(
        .SOF_BYTE       (SOF),
        .MAX_LEN        (MAX_LEN),
        .RD_WAIT        (RD_WAIT),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .rx_data   (rx_data),
        .rx_empty  (rx_empty),
        .rx_pulse  (rx_pulse),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_count (err_count),
        .busy      (busy)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- uart_core Rx FIFO model ----------------
    // A rising rx_pulse pops the head into data_out; pulse shape is checked.
    always @(negedge clk) begin
        if (rx_pulse) begin
            if (high_run == 0) begin
                if (seen_pulse) check("pulse_low_gap", (low_run >= RD_WAIT) ? 1 : 0, 1);
                check("pop_nonempty", (fifo_q.size() != 0) ? 1 : 0, 1);
                if (fifo_q.size() != 0) begin
                    rx_data = fifo_q.pop_front();
                    pops++;
                end
                last_pulse_cyc = cyc;
                seen_pulse = 1'b1;
            end
            high_run++;
            low_run = 0;
        end else begin
            if (high_run != 0) check("pulse_width", high_run, 1);
            high_run = 0;
            low_run++;
        end
        rx_empty = (fifo_q.size() == 0);
    end

    // ---------------- frame-level model ----------------
    task automatic add_err();
        exp_q.push_back(10'h300);
        if (model_err < 255) model_err++;
    endtask

    // Walk seq as a frame stream; end of seq mid-frame means silence -> timeout.
    task automatic model_seq();
        int i;
        int len;
        logic [7:0] s;
        bit trunc;
        i = 0;
        while (i < seq.size()) begin
            if (seq[i] != SOF) begin
                i++;
                continue;
            end
            i++;
            if (i >= seq.size()) begin add_err(); break; end
            len = int'(seq[i]);
            i++;
            if (len == 0 || len > MAX_LEN) begin add_err(); continue; end
            s = 8'(len);
            trunc = 1'b0;
            for (int k = 0; k < len; k++) begin
                if (i >= seq.size()) begin trunc = 1'b1; break; end
                s = s + seq[i];
                exp_q.push_back({1'b0, (k == len - 1), seq[i]});
                i++;
            end
            if (trunc || i >= seq.size()) begin add_err(); break; end
            if (seq[i] == s) exp_q.push_back(10'h200);
            else             add_err();
            i++;
        end
    endtask

    // Pin the model against hand-computed event lists
    task automatic pin(input string nm, input int n, input logic [9:0] a, b, c, d, e);
        logic [9:0] lit[5];
        lit = '{a, b, c, d, e};
        check({nm, "_size"}, exp_q.size(), n);
        for (int k = 0; k < n && k < exp_q.size(); k++)
            check({nm, "_event"}, exp_q[k], lit[k]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_seq(input int from);
        for (int k = from; k < seq.size(); k++) fifo_q.push_back(seq[k]);
        pushed += seq.size() - from;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (n < 3000 && !(fifo_q.size() == 0 && exp_q.size() == 0 && !busy)) begin
            @(negedge clk);
            n++;
        end
        check(name, (n < 3000) ? 1 : 0, 1);
        repeat (8) @(negedge clk);
    endtask

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [9:0] got;
        logic [9:0] e;
        if (nrst && (m_valid || frame_ok || frame_err)) begin
            check("ok_err_exclusive", {31'd0, frame_ok & frame_err}, 0);
            got = m_valid ? {1'b0, m_last, m_data} : (frame_ok ? 10'h200 : 10'h300);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: got 0x%0h expected none", got);
            end else begin
                e = exp_q.pop_front();
                check("event", got, e);
                if (m_valid || frame_ok)
                    check("event_latency", cyc - last_pulse_cyc, RD_WAIT + 1);
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int n;
        #2 nrst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {rx_pulse, m_valid, m_last, frame_ok, frame_err, busy}, 0);
        check("reset_m_data", m_data, 0);
        check("reset_err_count", err_count, 0);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // Good frame
        seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        model_seq();
        pin("t1_model", 4, 10'h011, 10'h022, 10'h133, 10'h200, 10'h000);
        push_seq(0);
        wait_idle("t1_drain");
        check("t1_err_count", err_count, model_err);
        check("t1_err_count_lit", err_count, 0);

        // Noise then frame
        seq = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F};
        model_seq();
        pin("t2_model", 2, 10'h17E, 10'h200, 10'h000, 10'h000, 10'h000);
        push_seq(0);
        wait_idle("t2_drain");
        check("t2_err_count", err_count, 0);

        // Bad checksum, then a good frame
        seq = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00, 8'hA5, 8'h01, 8'h05, 8'h06};
        model_seq();
        pin("t3_model", 5, 10'h010, 10'h120, 10'h300, 10'h105, 10'h200);
        push_seq(0);
        wait_idle("t3_drain");
        check("t3_err_count", err_count, model_err);
        check("t3_err_count_lit", err_count, 1);

        // Bad LEN: zero, then MAX_LEN+1
        seq = '{8'hA5, 8'h00, 8'hA5, 8'h41};
        model_seq();
        pin("t4_model", 2, 10'h300, 10'h300, 10'h000, 10'h000, 10'h000);
        push_seq(0);
        wait_idle("t4_drain");
        check("t4_err_count", err_count, 3);

        // Timeout after a partial payload
        seq = '{8'hA5, 8'h02, 8'h10};
        model_seq();
        pin("t5_model", 2, 10'h010, 10'h300, 10'h000, 10'h000, 10'h000);
        push_seq(0);
        n = 0;
        while (!frame_err && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t5_err_seen", (n < 2000) ? 1 : 0, 1);
        check("t5_timeout_latency", cyc - last_pulse_cyc, RD_WAIT + TIMEOUT);
        @(negedge clk);
        check("t5_hunt", busy, 0);
        wait_idle("t5_drain");
        check("t5_err_count", err_count, 4);

        // Reset in the middle of the payload
        seq = '{8'hA5, 8'h03, 8'h44, 8'h55, 8'h66};
        exp_q.push_back(10'h044);
        push_seq(0);
        n = 0;
        while (!m_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t6_first_payload", (n < 200) ? 1 : 0, 1);
        #1 nrst = 1'b0;
        #1;
        check("t6_reset_outputs", {rx_pulse, m_valid, m_last, frame_ok, frame_err, busy}, 0);
        check("t6_reset_m_data", m_data, 0);
        check("t6_reset_err_count", err_count, 0);
        check("t6_prefix_consumed", exp_q.size(), 0);
        check("t6_fifo_left", fifo_q.size(), 2);
        exp_q.delete();
        model_err = 0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        // Leftover 55 66 is noise in HUNT; a fresh frame must still decode
        seq = '{8'h55, 8'h66, 8'hA5, 8'h02, 8'h0A, 8'h0B, 8'h17};
        model_seq();
        pin("t6_model", 3, 10'h00A, 10'h10B, 10'h200, 10'h000, 10'h000);
        push_seq(2);
        wait_idle("t6_drain");
        check("t6_err_count", err_count, 0);

        // Every pushed byte was popped exactly once
        check("pop_count", pops, pushed);
        check("fifo_empty", fifo_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
